ieee_int_to_float: RTL and testbench



---
 rtl/ieee_int_to_float_pkg.sv | 21 ++
 rtl/ieee_i2f_round_pack.sv | 33 +++
 rtl/ieee_int_to_float.sv | 124 ++++++++++++
 tb/tb_ieee_int_to_float.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/ieee_int_to_float_pkg.sv
// Shared field widths, constants and state encoding for the int-to-float converter.
// Used by ieee_int_to_float and ieee_i2f_round_pack.
package ieee_int_to_float_pkg;

  localparam int MAG_W      = 32;
  localparam int EXPO_W     = 8;
  localparam int FRAC_W     = 23;
  localparam int EXPO_BIAS  = 127;
  localparam int GUARD_BITS = MAG_W - 1 - FRAC_W;
  localparam int SIGN_POS   = EXPO_W + FRAC_W;
  localparam int COARSE_W   = 8;

  localparam logic [31:0] FP_POS_ZERO = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    DONE
  } state_t;

endpackage

// File: rtl/ieee_i2f_round_pack.sv
// Round-to-nearest-even and IEEE packing of a normalized magnitude.
// mant holds the bits below the leading one.
module ieee_i2f_round_pack
  import ieee_int_to_float_pkg::*;
(
  input  logic              sign,
  input  logic [EXPO_W-1:0] expo,
  input  logic [MAG_W-2:0]  mant,
  output logic [31:0]       result,
  output logic              inexact
);

  logic [FRAC_W-1:0] frac;
  logic [FRAC_W-1:0] frac_r;
  logic              carry;
  logic              guard;
  logic              sticky;
  logic              inc;
  logic [EXPO_W-1:0] expo_r;

  assign frac   = mant[MAG_W-2 -: FRAC_W];
  assign guard  = mant[GUARD_BITS-1];
  assign sticky = |mant[GUARD_BITS-2:0];
  assign inc    = guard & (sticky | frac[0]);

  assign {carry, frac_r} = {1'b0, frac} + {{FRAC_W{1'b0}}, inc};

  // A fraction carry renormalizes to 1.0 at the next exponent.
  assign expo_r  = expo + {{(EXPO_W-1){1'b0}}, carry};
  assign result  = {sign, expo_r, frac_r};
  assign inexact = guard | sticky;

endmodule

// File: rtl/ieee_int_to_float.sv
// Iterative 32-bit int to IEEE single converter with valid/ready on both sides.
// Define IEEE_I2F_COARSE_SHIFT_EN to allow 8-bit normalization steps.
module ieee_int_to_float #(
  parameter int EXPO_BIAS  = 127,
  parameter int EXPO_START = EXPO_BIAS + 31
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_int,
  input  logic        in_unsigned,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_float,
  output logic        out_inexact
);

  import ieee_int_to_float_pkg::*;

  localparam logic [EXPO_W-1:0] EXPO_INIT = EXPO_W'(EXPO_START);

  state_t            state, state_n;
  logic              sign, sign_n;
  logic [MAG_W-1:0]  mag, mag_n;
  logic [EXPO_W-1:0] expo, expo_n;
  logic              valid_n;
  logic [31:0]       float_n;
  logic              inexact_n;

  logic              acc_sign;
  logic [MAG_W-1:0]  acc_mag;
  logic [31:0]       pk_result;
  logic              pk_inexact;

  assign acc_sign = in_int[31] & ~in_unsigned;
  // 0x80000000 negates to itself, which is already the right magnitude.
  assign acc_mag  = acc_sign ? -in_int : in_int;
  assign in_ready = (state == IDLE);

  ieee_i2f_round_pack u_round_pack (
    .sign    (sign),
    .expo    (expo),
    .mant    (mag[MAG_W-2:0]),
    .result  (pk_result),
    .inexact (pk_inexact)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      sign        <= 1'b0;
      mag         <= '0;
      expo        <= '0;
      out_valid   <= 1'b0;
      out_float   <= FP_POS_ZERO;
      out_inexact <= 1'b0;
    end else begin
      state       <= state_n;
      sign        <= sign_n;
      mag         <= mag_n;
      expo        <= expo_n;
      out_valid   <= valid_n;
      out_float   <= float_n;
      out_inexact <= inexact_n;
    end
  end

  always_comb begin
    state_n   = state;
    sign_n    = sign;
    mag_n     = mag;
    expo_n    = expo;
    valid_n   = out_valid;
    float_n   = out_float;
    inexact_n = out_inexact;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          sign_n = acc_sign;
          mag_n  = acc_mag;
          expo_n = EXPO_INIT;
          if (acc_mag == '0) begin
            state_n   = DONE;
            valid_n   = 1'b1;
            float_n   = FP_POS_ZERO;
            inexact_n = 1'b0;
          end else begin
            state_n = NORM;
          end
        end
      end
      NORM: begin
        if (mag[MAG_W-1]) begin
          state_n   = DONE;
          valid_n   = 1'b1;
          float_n   = pk_result;
          inexact_n = pk_inexact;
        end else begin
`ifdef IEEE_I2F_COARSE_SHIFT_EN
          if (mag[MAG_W-1 -: COARSE_W] == '0) begin
            mag_n  = mag << COARSE_W;
            expo_n = expo - EXPO_W'(COARSE_W);
          end else begin
            mag_n  = mag << 1;
            expo_n = expo - 1'b1;
          end
`else
          mag_n  = mag << 1;
          expo_n = expo - 1'b1;
`endif
        end
      end
      DONE: begin
        if (out_ready) begin
          state_n = IDLE;
          valid_n = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ieee_int_to_float.sv
// Directed self-checking bench for ieee_int_to_float.
// Latency expectations follow IEEE_I2F_COARSE_SHIFT_EN when defined.
module tb_ieee_int_to_float;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_int;
  logic        in_unsigned;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_float;
  logic        out_inexact;

  int n_cmp;
  int n_bad;

  ieee_int_to_float dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_int      (in_int),
    .in_unsigned (in_unsigned),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_float   (out_float),
    .out_inexact (out_inexact)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edges after the accept edge until out_valid; -1 marks a zero operand.
  function automatic int exp_lat(input int lz);
    if (lz < 0) return 0;
`ifdef IEEE_I2F_COARSE_SHIFT_EN
    return lz / 8 + lz % 8 + 1;
`else
    return lz + 1;
`endif
  endfunction

  // Present one operand; lat is -1 if out_valid never rises.
  task automatic issue(input logic [31:0] v, input logic u,
                       input logic rdy, output int lat);
    in_int      = v;
    in_unsigned = u;
    out_ready   = rdy;
    in_valid    = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_int   = $urandom;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    in_valid    = 1'b0;
    in_int      = '0;
    in_unsigned = 1'b0;
    out_ready   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_out_valid got %b want 0", out_valid);
    end
    n_cmp++;
    if (out_float !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_out_float got %h want 0", out_float);
    end
    n_cmp++;
    if (out_inexact !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_out_inexact got %b want 0", out_inexact);
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [31:0] v;
    logic        u;
    logic [31:0] f;
    logic        x;
    int          lz;
  } vec_t;

  task automatic test_convert();
    vec_t vecs[9];
    int lat;
    vecs[0] = '{32'h0000_0001, 1'b0, 32'h3F80_0000, 1'b0, 31};
    vecs[1] = '{32'hFFFF_FFFF, 1'b0, 32'hBF80_0000, 1'b0, 31};
    vecs[2] = '{32'h8000_0000, 1'b0, 32'hCF00_0000, 1'b0, 0};
    vecs[3] = '{32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, -1};
    vecs[4] = '{32'h0100_0001, 1'b0, 32'h4B80_0000, 1'b1, 7};
    vecs[5] = '{32'h0100_0003, 1'b0, 32'h4B80_0002, 1'b1, 7};
    vecs[6] = '{32'hFFFF_FFFF, 1'b1, 32'h4F80_0000, 1'b1, 0};
    vecs[7] = '{32'h8000_0000, 1'b1, 32'h4F00_0000, 1'b0, 0};
    vecs[8] = '{32'h0000_0007, 1'b0, 32'h40E0_0000, 1'b0, 29};
    foreach (vecs[i]) begin
      issue(vecs[i].v, vecs[i].u, 1'b1, lat);
      n_cmp++;
      if (lat !== exp_lat(vecs[i].lz)) begin
        n_bad++;
        $display("FAIL latency[%0d] got %0d want %0d",
                 i, lat, exp_lat(vecs[i].lz));
      end
      n_cmp++;
      if (out_float !== vecs[i].f) begin
        n_bad++;
        $display("FAIL float[%0d] got %h want %h", i, out_float, vecs[i].f);
      end
      n_cmp++;
      if (out_inexact !== vecs[i].x) begin
        n_bad++;
        $display("FAIL inexact[%0d] got %b want %b",
                 i, out_inexact, vecs[i].x);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL handoff[%0d] got ready=%b valid=%b want 1/0",
                 i, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    int bad;
    issue(32'h0000_0064, 1'b0, 1'b0, lat);
    n_cmp++;
    if (lat !== exp_lat(25)) begin
      n_bad++;
      $display("FAIL bp_latency got %0d want %0d", lat, exp_lat(25));
    end
    bad = 0;
    in_valid = 1'b1;
    in_int   = 32'h1234_5678;
    repeat (5) begin
      if (out_valid !== 1'b1 || out_float !== 32'h42C8_0000 ||
          out_inexact !== 1'b0 || in_ready !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    n_cmp++;
    if (bad !== 0) begin
      n_bad++;
      $display("FAIL bp_hold got %0d bad cycles want 0 (float %h)",
               bad, out_float);
    end
    n_cmp++;
    if (out_float !== 32'h42C8_0000 || out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_value got %h valid=%b want 42c80000 valid=1",
               out_float, out_valid);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_handoff got ready=%b valid=%b want 1/0",
               in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    int seen;
    in_int      = 32'h0000_0001;
    in_unsigned = 1'b0;
    out_ready   = 1'b1;
    in_valid    = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #6;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL midreset_async got ready=%b valid=%b want 1/0",
               in_ready, out_valid);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    seen = 0;
    repeat (40) begin
      if (out_valid !== 1'b0) seen++;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_bad++;
      $display("FAIL midreset_novalid got %0d valid cycles want 0", seen);
    end
    issue(32'h0000_0007, 1'b0, 1'b1, lat);
    n_cmp++;
    if (lat !== exp_lat(29) || out_float !== 32'h40E0_0000) begin
      n_bad++;
      $display("FAIL midreset_next got %h lat %0d want 40e00000 lat %0d",
               out_float, lat, exp_lat(29));
    end
    @(posedge clk); #1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_convert();
    test_backpressure();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
